// File: rtl/test_sequencer.sv
// test_sequencer: runs up to N_TESTS sub-tests one after another over a start/done
// handshake, recording pass, fail and watchdog timeout for each enabled test.
module test_sequencer #(
    parameter int N_TESTS      = 4,
    parameter int IDX_W        = 4,
    parameter int TIMEOUT_W    = 16,
    parameter int TIMEOUT      = 1000,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [N_TESTS-1:0] enable_mask,
    output logic [N_TESTS-1:0] start,
    input  logic [N_TESTS-1:0] done,
    input  logic [N_TESTS-1:0] pass,
    output logic               busy,
    output logic               all_done,
    output logic [IDX_W-1:0]   cur_idx,
    output logic [N_TESTS-1:0] pass_mask,
    output logic [N_TESTS-1:0] fail_mask,
    output logic [N_TESTS-1:0] tmo_mask,
    output logic               fail_any
);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        RUN,
        RELEASE,
        FINISH
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic [N_TESTS-1:0]   enLatched;
    logic [N_TESTS-1:0]   oneHot;
    logic [TIMEOUT_W-1:0] watchdog;
    logic                 curEn;
    logic                 curDone;
    logic                 curPass;
    logic                 curTmo;
    logic                 isLast;
    logic                 wdExpired;

    // Masking with the one-hot selector avoids indexing with a wider-than-needed cur_idx.
    assign oneHot    = N_TESTS'(1) << cur_idx;
    assign curEn     = |(enLatched & oneHot);
    assign curDone   = |(done & oneHot);
    assign curPass   = |(pass & oneHot);
    assign curTmo    = |(tmo_mask & oneHot);
    assign isLast    = (cur_idx == IDX_W'(N_TESTS - 1));
    assign wdExpired = (watchdog == TIMEOUT_W'(TIMEOUT - 1));

    // Decoded from the state register, so start falls together with an async reset.
    assign start    = (state == RUN) ? oneHot : '0;
    assign busy     = (state == SEEK) || (state == RUN) || (state == RELEASE);
    assign all_done = (state == FINISH);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: stateNext gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (run) stateNext = SEEK;
            end
            SEEK: begin
                if (curEn)       stateNext = RUN;
                else if (isLast) stateNext = FINISH;
            end
            RUN: begin
                if (curDone || wdExpired) stateNext = RELEASE;
            end
            RELEASE: begin
                if (!curDone || curTmo) begin
                    if (((STOP_ON_FAIL != 0) && fail_any) || isLast) stateNext = FINISH;
                    else                                             stateNext = SEEK;
                end
            end
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enLatched <= '0;
            watchdog  <= '0;
            cur_idx   <= '0;
            pass_mask <= '0;
            fail_mask <= '0;
            tmo_mask  <= '0;
            fail_any  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        enLatched <= enable_mask;
                        cur_idx   <= '0;
                        pass_mask <= '0;
                        fail_mask <= '0;
                        tmo_mask  <= '0;
                        fail_any  <= 1'b0;
                    end
                end
                SEEK: begin
                    if (curEn)        watchdog <= '0;
                    else if (!isLast) cur_idx  <= cur_idx + IDX_W'(1);
                end
                RUN: begin
                    // Bounded by TIMEOUT-1 before leaving RUN, so it cannot wrap.
                    watchdog <= watchdog + TIMEOUT_W'(1);
                    if (curDone) begin
                        if (curPass) begin
                            pass_mask <= pass_mask | oneHot;
                        end else begin
                            fail_mask <= fail_mask | oneHot;
                            fail_any  <= 1'b1;
                        end
                    end else if (wdExpired) begin
                        tmo_mask <= tmo_mask | oneHot;
                        fail_any <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (stateNext == SEEK) cur_idx <= cur_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: two instances (continue / stop-on-fail) driven by the same
// runs, with a transaction-level timeline model checked against the DUT on every cycle.
module tb_test_sequencer;

    localparam int N     = 4;
    localparam int IW    = 4;
    localparam int TMO   = 20;
    localparam int NEVER = 1000;
    localparam int MAXC  = 128;
    localparam int VW    = 4 * N + IW + 3;

    logic         clk;
    logic         reset_n;
    logic         run;
    logic [N-1:0] enable_mask;
    logic [N-1:0] startW [2];
    logic [N-1:0] doneR  [2];
    logic [N-1:0] passR  [2];
    logic         busyW  [2];
    logic         allDoneW [2];
    logic [IW-1:0] idxW  [2];
    logic [N-1:0] pmW    [2];
    logic [N-1:0] fmW    [2];
    logic [N-1:0] tmW    [2];
    logic         faW    [2];

    for (genvar g = 0; g < 2; g++) begin : gDut
        test_sequencer #(
            .N_TESTS(N), .IDX_W(IW), .TIMEOUT_W(16), .TIMEOUT(TMO), .STOP_ON_FAIL(g)
        ) uDut (
            .clk(clk), .reset_n(reset_n), .run(run), .enable_mask(enable_mask),
            .start(startW[g]), .done(doneR[g]), .pass(passR[g]), .busy(busyW[g]),
            .all_done(allDoneW[g]), .cur_idx(idxW[g]), .pass_mask(pmW[g]),
            .fail_mask(fmW[g]), .tmo_mask(tmW[g]), .fail_any(faW[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [VW-1:0] pack(input logic [N-1:0] st, input logic b,
                                           input logic ad, input logic [IW-1:0] idx,
                                           input logic [N-1:0] pm, input logic [N-1:0] fm,
                                           input logic [N-1:0] tm, input logic fa);
        return {st, b, ad, idx, pm, fm, tm, fa};
    endfunction

    // Sub-test behaviour for the current run.
    int           dly [N];
    bit           pv  [N];
    int           rel [N];
    logic [N-1:0] cfgEn = '0;
    bit           noiseOn = 1'b0;

    // Expected timeline: index 0 is the cycle after the edge that accepts run.
    logic [VW-1:0] expVec [2][MAXC];
    logic [VW-1:0] idleVec [2];
    int            tFin [2];

    task automatic buildModel(input int u, input bit stop, input logic [N-1:0] en);
        int t = 0;
        logic [N-1:0] pm = '0;
        logic [N-1:0] fm = '0;
        logic [N-1:0] tm = '0;
        logic [IW-1:0] idx = '0;
        for (int i = 0; i < N; i++) begin
            bit to;
            int k;
            int len;
            idx = IW'(i);
            expVec[u][t] = pack('0, 1'b1, 1'b0, idx, pm, fm, tm, |(fm | tm));
            t++;
            if (en[i]) begin
                to  = dly[i] > TMO - 1;
                k   = to ? TMO : dly[i] + 1;
                len = to ? 1 : rel[i] + 1;
                repeat (k) begin
                    expVec[u][t] = pack(N'(1) << i, 1'b1, 1'b0, idx, pm, fm, tm, |(fm | tm));
                    t++;
                end
                if (to)         tm[i] = 1'b1;
                else if (pv[i]) pm[i] = 1'b1;
                else            fm[i] = 1'b1;
                repeat (len) begin
                    expVec[u][t] = pack('0, 1'b1, 1'b0, idx, pm, fm, tm, |(fm | tm));
                    t++;
                end
                if (stop && ((fm | tm) != '0)) break;
            end
        end
        expVec[u][t] = pack('0, 1'b0, 1'b1, idx, pm, fm, tm, |(fm | tm));
        tFin[u]      = t;
        idleVec[u]   = pack('0, 1'b0, 1'b0, idx, pm, fm, tm, |(fm | tm));
    endtask

    // Compare process.
    bit active = 1'b0;
    int tc = 0;

    always @(negedge clk) begin
        if (active) begin
            for (int u = 0; u < 2; u++) begin
                logic [VW-1:0] act;
                logic [VW-1:0] req;
                act = pack(startW[u], busyW[u], allDoneW[u], idxW[u], pmW[u], fmW[u], tmW[u], faW[u]);
                req = (tc <= tFin[u]) ? expVec[u][tc] : idleVec[u];
                check($sformatf("dut%0d cycle%0d {start,busy,all_done,idx,pass,fail,tmo,any}", u, tc),
                      32'(act), 32'(req));
            end
            tc++;
        end
    end

    // Start-pulse monitor.
    logic [N-1:0] everHigh [2];
    int           curLen  [2][N];
    int           lastLen [2][N];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < N; i++) begin
                if (startW[u][i] === 1'b1) begin
                    everHigh[u][i] = 1'b1;
                    curLen[u][i]++;
                end else if (curLen[u][i] != 0) begin
                    lastLen[u][i] = curLen[u][i];
                    curLen[u][i]  = 0;
                end
            end
    end

    // Sub-test responders: 4-phase handshake with programmable done delay and release delay.
    int ph  [2][N];
    int cnt [2][N];

    always @(posedge clk) begin
        #2;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < N; i++) begin
                passR[u][i] = 1'($urandom);
                if (!reset_n) begin
                    ph[u][i] = 0; cnt[u][i] = 0; doneR[u][i] = 1'b0;
                end else if (!cfgEn[i]) begin
                    ph[u][i] = 0;
                    doneR[u][i] = noiseOn ? 1'($urandom) : 1'b0;
                end else begin
                    if (ph[u][i] == 0 && startW[u][i]) begin ph[u][i] = 1; cnt[u][i] = 0; end
                    if (ph[u][i] == 1) begin
                        if (!startW[u][i]) ph[u][i] = 0;
                        else if (cnt[u][i] == dly[i]) begin
                            doneR[u][i] = 1'b1; passR[u][i] = pv[i]; ph[u][i] = 2;
                        end else cnt[u][i]++;
                    end else if (ph[u][i] == 2 && !startW[u][i]) begin
                        ph[u][i] = 3; cnt[u][i] = 0;
                    end
                    if (ph[u][i] == 3) begin
                        if (cnt[u][i] == rel[i]) begin doneR[u][i] = 1'b0; ph[u][i] = 0; end
                        else cnt[u][i]++;
                    end
                end
            end
    end

    task automatic setAll(input int d, input bit p, input int r);
        for (int i = 0; i < N; i++) begin dly[i] = d; pv[i] = p; rel[i] = r; end
    endtask

    task automatic startRun(input logic [N-1:0] en);
        cfgEn = en;
        buildModel(0, 1'b0, en);
        buildModel(1, 1'b1, en);
        everHigh[0] = '0;
        everHigh[1] = '0;
        @(posedge clk); #1;
        run = 1'b1; enable_mask = en;
        @(posedge clk); #1;
        run = 1'b0; enable_mask = N'($urandom);
        tc = 0; active = 1'b1; noiseOn = 1'b1;
    endtask

    task automatic doRun(input logic [N-1:0] en, input bit extra);
        int cur = 0;
        int last;
        startRun(en);
        if (extra) begin
            @(posedge clk); #1; run = 1'b1; enable_mask = N'($urandom);
            @(posedge clk); #1; run = 1'b0;
            cur = 2;
            if (tFin[0] == tFin[1]) begin
                while (cur < tFin[0]) begin @(posedge clk); #1; cur++; end
                run = 1'b1; enable_mask = N'($urandom);
                @(posedge clk); #1; run = 1'b0; cur++;
            end
        end
        last = ((tFin[0] > tFin[1]) ? tFin[0] : tFin[1]) + 3;
        while (cur < last) begin @(posedge clk); #1; cur++; end
        active = 1'b0; noiseOn = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit found;
        int r;
        doneR[0] = '0; doneR[1] = '0; passR[0] = '0; passR[1] = '0;
        everHigh[0] = '0; everHigh[1] = '0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < N; i++) begin
                ph[u][i] = 0; cnt[u][i] = 0; curLen[u][i] = 0; lastLen[u][i] = 0;
            end
        reset_n = 1'b0; run = 1'b0; enable_mask = '0;
        setAll(2, 1'b1, 0);
        repeat (3) @(posedge clk); #1;
        for (int u = 0; u < 2; u++)
            check($sformatf("dut%0d reset state", u),
                  32'(pack(startW[u], busyW[u], allDoneW[u], idxW[u], pmW[u], fmW[u], tmW[u], faW[u])), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // All four pass, done 5 cycles after start.
        setAll(5, 1'b1, 1);
        doRun(4'b1111, 1'b0);
        check("t1 pass_mask", 32'(pmW[0]), 32'hf);
        check("t1 fail_any", 32'(faW[0]), 32'd0);
        check("t1 stop-inst pass_mask", 32'(pmW[1]), 32'h f);

        // Sparse mask, test2 fails.
        setAll(3, 1'b1, 2);
        pv[2] = 1'b0;
        doneR[0] = '0; doneR[1] = '0;
        doRun(4'b0101, 1'b0);
        check("t2 start[1],start[3] never high", 32'(everHigh[0] & 4'b1010), 32'd0);
        check("t2 pass_mask", 32'(pmW[0]), 32'h1);
        check("t2 fail_mask", 32'(fmW[0]), 32'h4);

        // Test1 never answers: watchdog.
        setAll(2, 1'b1, 0);
        dly[1] = NEVER;
        doRun(4'b1111, 1'b0);
        check("t3 start[1] high cycles", 32'(lastLen[0][1]), 32'd20);
        check("t3 tmo_mask", 32'(tmW[0]), 32'h2);
        check("t3 test2 started", 32'(everHigh[0][2]), 32'd1);

        // Test0 fails: stop-on-fail instance aborts.
        setAll(2, 1'b1, 1);
        pv[0] = 1'b0;
        doRun(4'b1111, 1'b0);
        check("t4 stop start[3:1] never high", 32'(everHigh[1] & 4'b1110), 32'd0);
        check("t4 stop fail_mask", 32'(fmW[1]), 32'h1);
        check("t4 continue all started", 32'(everHigh[0]), 32'hf);

        // Empty mask plus runs while busy and in the finish cycle.
        doRun(4'b0000, 1'b1);
        check("t6 model all_done offset", 32'(tFin[0]), 32'd4);
        check("t6 no start pulses", 32'(everHigh[0] | everHigh[1]), 32'd0);

        // Reset while start[2] is high, then a clean rerun.
        setAll(3, 1'b1, 1);
        startRun(4'b1111);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            found = (startW[0][2] === 1'b1);
        end
        check("t5 start[2] reached", 32'(found), 32'd1);
        active = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++)
            check($sformatf("t5 dut%0d outputs at async reset", u),
                  32'(pack(startW[u], busyW[u], allDoneW[u], idxW[u], pmW[u], fmW[u], tmW[u], faW[u])), 32'd0);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1; noiseOn = 1'b0;
        repeat (2) @(posedge clk);
        doRun(4'b1111, 1'b0);
        check("t5 rerun pass_mask", 32'(pmW[0]), 32'hf);

        // Randomised runs.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                if (r < 7)       dly[i] = $urandom_range(0, 6);
                else if (r == 7) dly[i] = TMO - 1;
                else if (r == 8) dly[i] = TMO;
                else             dly[i] = NEVER;
                pv[i]  = ($urandom_range(0, 3) != 0);
                rel[i] = $urandom_range(0, 3);
            end
            doRun(N'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
